// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// cordic_pkg : shared CORDIC operation, response and tag types
// Revision   : 1.0
// ============================================================================
package cordic_pkg;

  localparam int CORDIC_LANES    = 4;
  localparam int CORDIC_PIPE_LAT = 16;
  localparam int CORDIC_DW       = 16;
  localparam int CORDIC_EW       = 8;
  localparam int CORDIC_LANE_W   = 4;

  typedef struct packed {
    logic                 valid;
    logic [CORDIC_DW-1:0] x;
    logic [CORDIC_DW-1:0] y;
    logic [CORDIC_DW-1:0] z;
    logic                 fp_sign;
    logic [CORDIC_EW-1:0] fp_exponent;
    logic                 override;
    logic [CORDIC_DW-1:0] override_val;
  } cordic_reg;

  typedef struct packed {
    logic [CORDIC_LANE_W-1:0] lane;
    logic [CORDIC_DW-1:0]     x;
    logic [CORDIC_DW-1:0]     y;
    logic [CORDIC_DW-1:0]     z;
    logic                     fp_sign;
    logic [CORDIC_EW-1:0]     fp_exponent;
    logic                     override;
    logic [CORDIC_DW-1:0]     override_val;
  } cordic_rsp_t;

  typedef struct packed {
    logic                     valid;
    logic [CORDIC_LANE_W-1:0] lane;
  } cordic_tag_t;

  function automatic cordic_rsp_t make_rsp(input logic [CORDIC_LANE_W-1:0] lane,
                                           input cordic_reg r);
    cordic_rsp_t o;
    o.lane         = lane;
    o.x            = r.x;
    o.y            = r.y;
    o.z            = r.z;
    o.fp_sign      = r.fp_sign;
    o.fp_exponent  = r.fp_exponent;
    o.override     = r.override;
    o.override_val = r.override_val;
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_arbiter_if.sv
`default_nettype none
// ============================================================================
// cordic_arbiter_if : request, CORDIC pipe and response signals of the arbiter
// Revision          : 1.0
// ============================================================================
interface cordic_arbiter_if
  import cordic_pkg::*;
#(
  parameter int NUM_LANES = CORDIC_LANES
);

  logic [NUM_LANES-1:0]      req_valid;
  logic [NUM_LANES-1:0]      req_ready;
  cordic_reg [NUM_LANES-1:0] req_data;
  cordic_reg                 pipe_in;
  cordic_reg                 pipe_out;
  logic                      rsp_valid;
  logic                      rsp_ready;
  cordic_rsp_t               rsp_data;
  logic                      busy;
  logic                      tag_err;

  modport master (
    output req_valid, req_data, pipe_out, rsp_ready,
    input  req_ready, pipe_in, rsp_valid, rsp_data, busy, tag_err
  );

  modport slave (
    input  req_valid, req_data, pipe_out, rsp_ready,
    output req_ready, pipe_in, rsp_valid, rsp_data, busy, tag_err
  );

endinterface
`default_nettype wire

// File: rtl/cordic_rsp_fifo.sv
`default_nettype none
// ============================================================================
// cordic_rsp_fifo : synchronous response FIFO, push and pop allowed together
// Revision        : 1.0
// ============================================================================
module cordic_rsp_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  cordic_rsp_t data_i,
  input  logic        pop_i,
  output cordic_rsp_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cordic_rsp_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign w_pop   = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= bump(wr_ptr_q);
      if (w_pop)  rd_ptr_q <= bump(rd_ptr_q);
      if (w_push && !w_pop)      count_q <= count_q + CNT_W'(1);
      else if (!w_push && w_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
// cordic_arbiter : round-robin issue into a fixed-latency CORDIC pipeline
//                  with credit-protected in-order response buffering
// Revision       : 1.0
// ============================================================================
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_LANES = CORDIC_LANES,
  parameter int PIPE_LAT  = CORDIC_PIPE_LAT,
  parameter int RSP_DEPTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  cordic_arbiter_if.slave  bus
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  logic [LANE_W-1:0]    rr_ptr_q;
  logic [LANE_W-1:0]    rr_ptr_d;
  logic [CNT_W-1:0]     credits_q;
  logic [CNT_W-1:0]     credits_d;
  cordic_reg            pipe_in_q;
  cordic_reg            pipe_in_d;
  logic                 tag_err_q;
  logic                 tag_err_d;
  cordic_tag_t          tag_q [PIPE_LAT+1];

  logic                 w_grant;
  logic [LANE_W-1:0]    w_lane;
  logic [NUM_LANES-1:0] w_ready;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  cordic_rsp_t          w_push_data;
  cordic_rsp_t          w_head;

  // Scan downward so the lane closest above rr_ptr is the last (winning) hit.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = 1'b0;
    w_lane  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (bus.req_valid[idx]) begin
        w_grant = 1'b1;
        w_lane  = LANE_W'(idx);
      end
    end
    if (rst || credits_q == '0 || w_fifo_full) w_grant = 1'b0;
    w_ready = '0;
    if (w_grant) w_ready[w_lane] = 1'b1;
  end

  assign w_pop       = !w_fifo_empty && bus.rsp_ready;
  assign w_push      = tag_q[PIPE_LAT].valid;
  assign w_push_data = make_rsp(tag_q[PIPE_LAT].lane, bus.pipe_out);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_grant) rr_ptr_d = (w_lane == LANE_W'(NUM_LANES - 1)) ? '0 : w_lane + LANE_W'(1);
    pipe_in_d = '0;
    if (w_grant) begin
      pipe_in_d       = bus.req_data[w_lane];
      pipe_in_d.valid = 1'b1;
    end
    credits_d = credits_q;
    if (w_grant && !w_pop)      credits_d = credits_q - CNT_W'(1);
    else if (!w_grant && w_pop) credits_d = credits_q + CNT_W'(1);
    tag_err_d = tag_err_q | (bus.pipe_out.valid != tag_q[PIPE_LAT].valid);
  end

  // tag_q[k] describes the op that entered pipe_in k cycles ago.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      credits_q <= CNT_W'(RSP_DEPTH);
      pipe_in_q <= '0;
      tag_err_q <= 1'b0;
      for (int i = 0; i <= PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      credits_q       <= credits_d;
      pipe_in_q       <= pipe_in_d;
      tag_err_q       <= tag_err_d;
      tag_q[0].valid  <= w_grant;
      tag_q[0].lane   <= CORDIC_LANE_W'(w_lane);
      for (int i = 1; i <= PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  cordic_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign bus.req_ready = w_ready;
  assign bus.pipe_in   = pipe_in_q;
  assign bus.rsp_valid = !w_fifo_empty;
  assign bus.rsp_data  = w_head;
  assign bus.busy      = (credits_q != CNT_W'(RSP_DEPTH));
  assign bus.tag_err   = tag_err_q;

endmodule
`default_nettype wire

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of requesting lanes.
REQ-002 SHALL have parameter PIPE_LAT, default 16, fixed CORDIC pipeline latency in cycles.
REQ-003 SHALL have parameter RSP_DEPTH, default 20, response FIFO entries; RSP_DEPTH >= PIPE_LAT+1.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: req_valid  input  NUM_LANES  per-lane request valid.
REQ-007 SHALL have port: req_ready  output  NUM_LANES  per-lane accept, one-hot or zero.
REQ-008 SHALL have port: req_data  input  NUM_LANES x cordic_reg  per-lane operation; its valid field is ignored.
REQ-009 SHALL have port: pipe_in  output  cordic_reg  issue into CORDIC stage 0.
REQ-010 SHALL have port: pipe_out  input  cordic_reg  final CORDIC stage output.
REQ-011 SHALL have port: rsp_valid / rsp_ready  output / input  1 each  response handshake.
REQ-012 SHALL have port: rsp_data  output  cordic_rsp_t  result plus originating lane.
REQ-013 SHALL have port: busy  output  1  high while any op is in flight or buffered.
REQ-014 SHALL have port: tag_err  output  1  sticky tag/valid mismatch flag.

Function
REQ-015 SHALL grant at most one lane per cycle: first lane with req_valid high, searching upward from rr_ptr with wrap-around.
REQ-016 SHALL advance rr_ptr to (granted lane + 1) mod NUM_LANES on each grant; rr_ptr unchanged otherwise.
REQ-017 SHALL grant only when credits > 0; req_ready is combinational from req_valid, rr_ptr and credits.
REQ-018 SHALL register the granted req_data into pipe_in with valid=1 one cycle after the grant; pipe_in.valid=0 on cycles following no grant.
REQ-019 SHALL shift {valid, lane} through a PIPE_LAT+1-entry tag delay line aligned with pipe_in, so tag and pipe_out emerge on the same cycle.
REQ-020 SHALL push {tag lane, pipe_out fields} into the response FIFO when the tag is valid.
REQ-021 SHALL set tag_err and hold it until reset when pipe_out.valid differs from tag valid.
REQ-022 SHALL maintain credits = RSP_DEPTH - (in-flight + FIFO occupancy): -1 on grant, +1 on rsp handshake, unchanged when both occur in one cycle.
REQ-023 SHALL never overflow the FIFO; credits guarantee a slot for every issued op, and a push is never dropped.
REQ-024 SHALL present the FIFO head on rsp_data with rsp_valid = FIFO non-empty; pop on rsp_valid && rsp_ready.
REQ-025 SHALL support a simultaneous push and pop, including when the FIFO is full; occupancy is then unchanged.
REQ-026 SHALL sustain one grant per cycle indefinitely when rsp_ready is held high.
REQ-027 SHALL drive busy = (credits != RSP_DEPTH).
REQ-028 SHALL return responses in issue order, with total latency grant -> rsp_valid = PIPE_LAT+2 cycles when the FIFO is empty.

Reset
REQ-029 SHALL on rst force: rr_ptr=0, credits=RSP_DEPTH, tag line all invalid, FIFO empty, pipe_in=0, rsp_valid=0, req_ready=0, busy=0, tag_err=0.
REQ-030 SHALL discard in-flight ops on reset mid-operation; pipe_out results arriving after reset carry invalid tags and set tag_err only if pipe_out.valid=1.

Structure
REQ-031 SHALL add cordic_rsp_t (lane id, x, y, z, fp_sign, fp_exponent, override, override_val) and the default constants CORDIC_LANES and CORDIC_PIPE_LAT to cordic_pkg.
REQ-032 SHALL instantiate one sub-module, cordic_rsp_fifo: a synchronous FIFO with depth parameter, full and empty flags, and simultaneous push/pop support.

Verification
REQ-033 Reset, then all lanes idle for 50 cycles -> busy=0, rsp_valid=0, credits=20, tag_err=0.
REQ-034 All 4 lanes valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,...; one grant per cycle; rsp lanes in the same order; first rsp_valid at cycle 18.
REQ-035 Lanes 1 and 3 valid, rr_ptr=2 -> lane 3 granted, rr_ptr=0, then lane 1 granted, rr_ptr=2.
REQ-036 rsp_ready=0 while 25 requests are offered -> exactly 20 accepted; req_ready=0 thereafter; after one pop, exactly one more grant.
REQ-037 Model injects pipe_out.valid=1 with an invalid tag -> tag_err=1 and held until rst.
REQ-038 rst asserted with 10 ops in flight -> all outputs reach reset values asynchronously; no stale rsp_valid after release.
